// File: rtl/burst_mem_model_if.sv
// burst_mem_model_if: request/response bundle between an L2 cache and the burst memory model
interface burst_mem_model_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] addr;
    logic                  read;
    logic                  write;
    logic [63:0]           wdata;
    logic [63:0]           rdata;
    logic                  resp;
    logic                  error;
    modport master (output addr, read, write, wdata, input rdata, resp, error);
    modport slave (input addr, read, write, wdata, output rdata, resp, error);
endinterface

// File: rtl/burst_mem_model.sv
// burst_mem_model: line-granular burst memory with fixed read/write latency and a sticky protocol-error flag
module burst_mem_model #(
    parameter int DRAM_PARAM_BURST_LEN = 16,
    parameter int ADDR_WIDTH           = 32,
    parameter int MEM_LINES            = 256,
    parameter int READ_LATENCY         = 8,
    parameter int WRITE_LATENCY        = 4
) (
    input logic              clk,
    input logic              rst,
    burst_mem_model_if.slave bmem
);
    localparam int OFF  = $clog2(DRAM_PARAM_BURST_LEN * 8);
    localparam int IW   = $clog2(MEM_LINES);
    localparam int BW   = $clog2(DRAM_PARAM_BURST_LEN);
    localparam int LMAX = READ_LATENCY > WRITE_LATENCY ? READ_LATENCY : WRITE_LATENCY;
    localparam int CMAX = LMAX > DRAM_PARAM_BURST_LEN ? LMAX : DRAM_PARAM_BURST_LEN;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  resp_q, resp_d;
    logic [63:0]           rdata_q;
    logic                  err_q;
    logic                  viol;
    logic                  rd_en, wr_en;
    logic [BW-1:0]         beat;
    logic [IW-1:0]         wr_idx;
    logic [63:0]           mem_q [MEM_LINES*DRAM_PARAM_BURST_LEN];

    // The last beat and the write-done pulse are emitted on the edge that returns to IDLE,
    // so a new request is taken on the very next edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        resp_d  = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        beat    = cnt_q[BW-1:0];
        wr_idx  = addr_q[OFF +: IW];
        viol    = 1'b0;
        case (state_q)
            IDLE: begin
                viol = (bmem.read && bmem.write) ||
                       ((bmem.read || bmem.write) && bmem.addr[OFF-1:0] != '0);
                if (bmem.read && !bmem.write) begin
                    state_d = RD_WAIT;
                    addr_d  = bmem.addr;
                    cnt_d   = '0;
                end else if (bmem.write && !bmem.read) begin
                    state_d = WR_BURST;
                    addr_d  = bmem.addr;
                    cnt_d   = CW'(1);
                    wr_en   = 1'b1;
                    beat    = '0;
                    wr_idx  = bmem.addr[OFF +: IW];
                end
            end
            RD_WAIT: begin
                if (cnt_q == CW'(READ_LATENCY - 1)) begin
                    state_d = RD_BURST;
                    rd_en   = 1'b1;
                    resp_d  = 1'b1;
                    beat    = '0;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_BURST: begin
                rd_en   = 1'b1;
                resp_d  = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(DRAM_PARAM_BURST_LEN - 1) ? IDLE : RD_BURST;
            end
            WR_BURST: begin
                wr_en = 1'b1;
                viol  = !bmem.write;
                if (cnt_q == CW'(DRAM_PARAM_BURST_LEN - 1)) begin
                    state_d = WR_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_WAIT: begin
                viol = bmem.write || bmem.read;
                if (cnt_q == CW'(WRITE_LATENCY - 1)) begin
                    state_d = IDLE;
                    resp_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && bmem.addr != addr_q) viol = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            resp_q  <= resp_d;
            err_q   <= err_q | viol;
            if (rd_en) rdata_q <= mem_q[{addr_q[OFF +: IW], beat}];
        end
    end

    // Storage is never cleared; beats already written survive a mid-burst reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[{wr_idx, beat}] <= bmem.wdata;
    end

    assign bmem.rdata = rdata_q;
    assign bmem.resp  = resp_q;
    assign bmem.error = err_q;
endmodule

// File: tb/tb_burst_mem_model.sv
// tb_burst_mem_model: directed and randomized checks of burst_mem_model against a line-array reference model
module tb_burst_mem_model;
    localparam int BL    = 16;
    localparam int RL    = 8;
    localparam int WL    = 4;
    localparam int LINES = 256;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   resp_cycles;

    logic [63:0] model [LINES][BL];
    bit          known [LINES];
    logic [63:0] wbuf  [BL];

    burst_mem_model_if #(.ADDR_WIDTH(32)) bus ();

    burst_mem_model dut (
        .clk  (clk),
        .rst  (rst),
        .bmem (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.resp) resp_cycles++;

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 128) % LINES);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input int drop, input string tag);
        int n;
        int idx;
        bus.addr = a;
        for (int k = 0; k < BL; k++) begin
            bus.write = (k != drop);
            bus.wdata = wbuf[k];
            tick();
        end
        bus.write = 1'b0;
        n = 0;
        while (!bus.resp && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " wr_latency"}, 64'(n), 64'(WL));
        tick();
        chk({tag, " wr_pulse_end"}, 64'(bus.resp), 64'(0));
        idx = line_of(a);
        for (int k = 0; k < BL; k++) model[idx][k] = wbuf[k];
        known[idx] = (drop < 0);
    endtask

    task automatic do_read(input logic [31:0] a, input string tag);
        int n;
        int idx;
        idx = line_of(a);
        bus.addr = a;
        bus.read = 1'b1;
        tick();
        n = 0;
        while (!bus.resp && n < 40) begin
            tick();
            n++;
        end
        bus.read = 1'b0;
        chk({tag, " rd_latency"}, 64'(n), 64'(RL));
        for (int k = 0; k < BL; k++) begin
            if (k > 0) tick();
            chk($sformatf("%s resp[%0d]", tag, k), 64'(bus.resp), 64'(1));
            if (known[idx]) chk($sformatf("%s beat[%0d]", tag, k), bus.rdata, model[idx][k]);
        end
        tick();
        chk({tag, " resp_end"}, 64'(bus.resp), 64'(0));
    endtask

    initial begin
        int n;
        int base;
        logic [31:0] addrs [6];
        vectors     = 0;
        miscompares = 0;
        resp_cycles = 0;
        rst         = 1'b1;
        bus.addr    = '0;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.wdata   = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset resp", 64'(bus.resp), 64'(0));
        chk("reset rdata", bus.rdata, 64'(0));
        chk("reset error", 64'(bus.error), 64'(0));

        for (int k = 0; k < BL; k++) wbuf[k] = 64'h1111_0000 + 64'(k);
        do_write(32'h100, -1, "w100");
        do_read(32'h100, "r100");
        chk("w100 error", 64'(bus.error), 64'(0));

        for (int k = 0; k < BL; k++) wbuf[k] = {$urandom, $urandom};
        do_write(32'h0, -1, "w0");
        for (int k = 0; k < BL; k++) wbuf[k] = {$urandom, $urandom};
        do_write(32'h8000, -1, "w8000");
        do_read(32'h0, "wrap");

        for (int i = 0; i < 6; i++) begin
            addrs[i] = 32'($urandom_range(0, 1023)) * 128;
            for (int k = 0; k < BL; k++) wbuf[k] = {$urandom, $urandom};
            do_write(addrs[i], -1, $sformatf("rw%0d", i));
        end
        for (int i = 5; i >= 0; i--) do_read(addrs[i], $sformatf("rr%0d", i));
        chk("random error", 64'(bus.error), 64'(0));

        do_read(32'h104, "unaligned");
        chk("unaligned error", 64'(bus.error), 64'(1));
        tick();
        tick();
        chk("unaligned sticky", 64'(bus.error), 64'(1));
        do_reset();
        chk("clear error", 64'(bus.error), 64'(0));

        bus.addr  = 32'h200;
        bus.read  = 1'b1;
        bus.write = 1'b1;
        tick();
        bus.read  = 1'b0;
        bus.write = 1'b0;
        tick();
        chk("rw both error", 64'(bus.error), 64'(1));
        chk("rw both no resp", 64'(bus.resp), 64'(0));
        do_reset();

        for (int k = 0; k < BL; k++) wbuf[k] = {$urandom, $urandom};
        do_write(32'h300, 5, "drop");
        chk("drop error", 64'(bus.error), 64'(1));

        bus.addr = 32'h100;
        bus.read = 1'b1;
        tick();
        n = 0;
        while (!bus.resp && n < 40) begin
            tick();
            n++;
        end
        bus.read = 1'b0;
        chk("abort rd_latency", 64'(n), 64'(RL));
        tick();
        tick();
        tick();
        chk("abort beat3", bus.rdata, model[line_of(32'h100)][3]);
        rst = 1'b1;
        tick();
        chk("abort resp", 64'(bus.resp), 64'(0));
        chk("abort error", 64'(bus.error), 64'(0));
        chk("abort rdata", bus.rdata, 64'(0));
        rst = 1'b0;
        tick();
        chk("abort idle resp", 64'(bus.resp), 64'(0));
        do_read(32'h100, "post_abort");

        base = resp_cycles;
        do_read(32'h0, "b2b_a");
        do_read(32'h100, "b2b_b");
        chk("b2b resp count", 64'(resp_cycles - base), 64'(2 * BL));
        chk("b2b error", 64'(bus.error), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
